seq_max_finder: RTL and testbench

//  Sequential controller that streams W-bit words through one shared greater-than comparator.
//  It tracks the running maximum of a framed input burst.
//  It sits between a word source (switches/UART/FIFO) and the display/consumer, and owns the

---
 rtl/seq_max_finder_pkg.sv | 14 +
 rtl/seq_max_finder_gt_cmp.sv | 12 +
 rtl/seq_max_finder.sv | 155 +++++++++++++++
 tb/tb_seq_max_finder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_max_finder_pkg.sv
// Shared definitions for seq_max_finder: FSM state encoding and default widths.
package seq_max_finder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FIRST = 2'b01,
    S_ACC   = 2'b10,
    S_DONE  = 2'b11
  } smf_state_t;

  localparam int SMF_W     = 4;
  localparam int SMF_CNT_W = 8;

endpackage

// File: rtl/seq_max_finder_gt_cmp.sv
// gt_cmp: purely combinational unsigned strict greater-than, the block's only comparator.
module gt_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  assign gt = (a > b);

endmodule

// File: rtl/seq_max_finder.sv
// seq_max_finder: running maximum / argmax / beat count over a framed burst.
// Optional max_idx port and index register are built only with SMF_INDEX_EN defined.
module seq_max_finder
  import seq_max_finder_pkg::*;
#(
  parameter int W     = SMF_W,
  parameter int CNT_W = SMF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  input  logic             din_last,
  output logic             din_ready,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     max_out,
  output logic [CNT_W-1:0] count
`ifdef SMF_INDEX_EN
  ,
  output logic [CNT_W-1:0] max_idx
`endif
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  smf_state_t       state_r;
  smf_state_t       next_state_s;
  logic             din_ready_r;
  logic             busy_r;
  logic             done_r;
  logic [W-1:0]     max_r;
  logic [CNT_W-1:0] count_r;
  logic             beat_s;
  logic             gt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  gt_cmp #(.W(W)) u_gt_cmp (
    .a  (din),
    .b  (max_r),
    .gt (gt_s)
  );

  // ready is a registered copy of the state, so valid never feeds back into acceptance
  assign beat_s = din_valid & din_ready_r;

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_FIRST;
        else       next_state_s = S_IDLE;
      end
      S_FIRST: begin
        if (beat_s && din_last) next_state_s = S_DONE;
        else if (beat_s)        next_state_s = S_ACC;
        else                    next_state_s = S_FIRST;
      end
      S_ACC: begin
        if (beat_s && din_last) next_state_s = S_DONE;
        else                    next_state_s = S_ACC;
      end
      S_DONE: begin
        if (start) next_state_s = S_FIRST;
        else       next_state_s = S_DONE;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register plus the status flags derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      din_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      din_ready_r <= (next_state_s == S_FIRST) || (next_state_s == S_ACC);
      busy_r      <= (next_state_s == S_FIRST) || (next_state_s == S_ACC);
      done_r      <= (next_state_s == S_DONE) && (state_r != S_DONE);
    end
  end

  // Running maximum and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      max_r   <= {W{1'b0}};
      count_r <= CNT_ZERO;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) count_r <= CNT_ZERO;
        end
        S_FIRST: begin
          if (beat_s) begin
            max_r   <= din;
            count_r <= CNT_ONE;
          end
        end
        S_ACC: begin
          if (beat_s) begin
            if (gt_s) max_r <= din;
            count_r <= sat_inc(count_r);
          end
        end
        default: begin
          max_r   <= {W{1'b0}};
          count_r <= CNT_ZERO;
        end
      endcase
    end
  end

`ifdef SMF_INDEX_EN
  logic [CNT_W-1:0] idx_r;

  // Index of the earliest maximum, taken from the pre-increment count
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r <= CNT_ZERO;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) idx_r <= CNT_ZERO;
        end
        S_FIRST: begin
          if (beat_s) idx_r <= CNT_ZERO;
        end
        S_ACC: begin
          if (beat_s && gt_s) idx_r <= count_r;
        end
        default: idx_r <= CNT_ZERO;
      endcase
    end
  end

  assign max_idx = idx_r;
`endif

  assign din_ready = din_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign max_out   = max_r;
  assign count     = count_r;

endmodule

// File: tb/tb_seq_max_finder.sv
// Self-checking bench for seq_max_finder; covers both SMF_INDEX_EN builds.
module tb_seq_max_finder;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] din;
  logic       din_valid;
  logic       din_last;
  logic       din_ready;
  logic       busy;
  logic       done;
  logic [3:0] max_out;
  logic [7:0] count;
`ifdef SMF_INDEX_EN
  logic [7:0] max_idx;
`endif

  seq_max_finder #(.W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
    .max_out   (max_out),
    .count     (count)
`ifdef SMF_INDEX_EN
    ,
    .max_idx   (max_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the accepted words of the current burst plus the last reported max.
  int q[$];
  int exp_max = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_count();
    return (q.size() > 255) ? 255 : q.size();
  endfunction

  function automatic int ref_max();
    int m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  function automatic int ref_idx();
    int m = ref_max();
    for (int i = 0; i < q.size(); i++)
      if (q[i] == m) return (i > 255) ? 255 : i;
    return 0;
  endfunction

  task automatic check_idx(input int exp);
`ifdef SMF_INDEX_EN
    check("max_idx", int'(max_idx), exp);
`else
    n_chk = n_chk + 0;
`endif
  endtask

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic arm();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    q.delete();
    check("arm_busy", int'(busy), 1);
    check("arm_ready", int'(din_ready), 1);
    check("arm_count", int'(count), 0);
    check("arm_max_held", int'(max_out), exp_max);
    check_idx(0);
  endtask

  task automatic send(input int d, input bit last, input bit stray_start);
    check("ready_before_beat", int'(din_ready), 1);
    din = d[3:0]; din_last = last; din_valid = 1'b1; start = stray_start;
    @(posedge clk); #1;
    din_valid = 1'b0; din_last = 1'b0; start = 1'b0;
    q.push_back(d);
    exp_max = ref_max();
    check("beat_max", int'(max_out), exp_max);
    check("beat_count", int'(count), ref_count());
    check_idx(ref_idx());
    check("beat_done", int'(done), int'(last));
    check("beat_busy", int'(busy), int'(!last));
  endtask

  task automatic idle(input int n, input bit stray_last, input bit stray_start);
    bit was_busy = busy;
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b0; din_last = stray_last; start = stray_start; din = 4'($urandom);
      @(posedge clk); #1;
      din_last = 1'b0; start = 1'b0;
      check("idle_count", int'(count), ref_count());
      check("idle_max", int'(max_out), exp_max);
      check("idle_done", int'(done), 0);
      check("idle_busy", int'(busy), int'(was_busy));
    end
  endtask

  task automatic burst(input int vals[$]);
    arm();
    foreach (vals[i]) send(vals[i], i == vals.size() - 1, 1'b0);
    idle(1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; din = 4'd0; din_valid = 1'b1; din_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(din_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_max", int'(max_out), 0);
    check("rst_count", int'(count), 0);
    check_idx(0);
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_ready", int'(din_ready), 0);
      check("idle_rst_done", int'(done), 0);
    end
    din_valid = 1'b0;

    burst('{3, 9, 5, 2});
    check("basic_max", int'(max_out), 9);
    check("basic_count", int'(count), 4);
    burst('{0, 15, 15, 0});
    check("ties_max", int'(max_out), 15);
    burst('{0, 0});
    burst('{7});
    check("single_count", int'(count), 1);

    // Backpressure gaps, stray start/last mid-burst, start coinciding with last beat
    arm();
    send(4, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b0);
    send(11, 1'b0, 1'b1);
    idle(1, 1'b0, 1'b1);
    send(6, 1'b0, 1'b0);
    send(11, 1'b1, 1'b1);
    idle(2, 1'b0, 1'b0);

    // Reset mid-burst
    arm();
    send(12, 1'b0, 1'b0);
    send(13, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete(); exp_max = 0;
    check("midrst_ready", int'(din_ready), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_max", int'(max_out), 0);
    check("midrst_count", int'(count), 0);
    check_idx(0);
    idle(1, 1'b0, 1'b0);
    burst('{1, 8, 2});

    // Randomized bursts with random gaps
    for (int b = 0; b < 8; b++) begin
      int len = $urandom_range(1, 12);
      arm();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), 1'($urandom), 1'($urandom));
        send($urandom_range(0, 15), i == len - 1, 1'b0);
      end
      idle(1, 1'b0, 1'b0);
    end

    // Counter saturation over a 300-beat burst
    arm();
    for (int i = 0; i < 300; i++) send($urandom_range(0, 14) + ((i == 280) ? 1 : 0), i == 299, 1'b0);
    check("sat_count", int'(count), 255);
    idle(1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
